// File: rtl/skein_nonce_scheduler.sv
// Nonce dispatcher and result filter for the skein512 core: sweeps an inclusive nonce range,
// tracks in-flight nonces through the core latency and queues hashes at or below the target.
module skein_nonce_scheduler #(
  parameter int unsigned PIPE_LATENCY   = 182,
  parameter int unsigned ISSUE_INTERVAL = 2,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [511:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [63:0]  work_target,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic         abort,
  output logic [511:0] core_midstate,
  output logic [95:0]  core_data,
  output logic [31:0]  core_nonce,
  output logic         core_issue,
  input  logic [511:0] core_hash,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic [63:0]  res_hash_hi,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int unsigned PhW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [63:0]       target_q;
  logic [31:0]       next_nonce_q;
  logic [31:0]       end_nonce_q;
  logic [PhW-1:0]    phase_q;

  logic [PIPE_LATENCY-1:0] tag_valid_q;
  logic [31:0]             tag_nonce_q [PIPE_LATENCY];

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]  fifo_nonce [FIFO_DEPTH];
  logic [63:0]  fifo_hash  [FIFO_DEPTH];

  logic        accept, kill, win, pop, full, push_ok, drop, chain_empty;
  logic [63:0] hash_hi;
  logic        unused_hash;

  assign hash_hi     = core_hash[511:448];
  assign unused_hash = ^core_hash[447:0];

  assign work_ready  = (state_q == StIdle) && !done;
  assign busy        = (state_q != StIdle);
  assign accept      = work_ready && work_valid;
  assign kill        = abort && (state_q != StIdle);
  // The issue still sitting in core_issue has not reached the chain yet.
  assign chain_empty = !(|tag_valid_q) && !core_issue;

  assign win     = tag_valid_q[PIPE_LATENCY-1] && (hash_hi <= target_q) && !kill;
  assign pop     = res_valid && res_ready;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = win && (!full || pop);
  assign drop    = win && full && !pop;

  assign res_valid   = (wr_ptr_q != rd_ptr_q);
  assign res_nonce   = fifo_nonce[rd_ptr_q[AW-1:0]];
  assign res_hash_hi = fifo_hash[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      target_q      <= '0;
      next_nonce_q  <= '0;
      end_nonce_q   <= '0;
      phase_q       <= '0;
      core_midstate <= '0;
      core_data     <= '0;
      core_nonce    <= '0;
      core_issue    <= 1'b0;
      done          <= 1'b0;
    end else begin
      done       <= 1'b0;
      core_issue <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            core_midstate <= work_midstate;
            core_data     <= work_data;
            target_q      <= work_target;
            next_nonce_q  <= work_nonce_start;
            end_nonce_q   <= work_nonce_end;
            phase_q       <= '0;
            state_q       <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            phase_q <= (phase_q == PhW'(ISSUE_INTERVAL - 1)) ? '0 : phase_q + PhW'(1);
            if (phase_q == '0) begin
              core_issue   <= 1'b1;
              core_nonce   <= next_nonce_q;
              next_nonce_q <= next_nonce_q + 32'd1;
              if (next_nonce_q == end_nonce_q) state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort || chain_empty) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
    end else if (kill) begin
      tag_valid_q <= '0;
    end else begin
      tag_valid_q <= {tag_valid_q[PIPE_LATENCY-2:0], core_issue};
    end
  end

  always_ff @(posedge clk) begin
    tag_nonce_q[0] <= core_nonce;
    for (int i = 1; i < PIPE_LATENCY; i++) tag_nonce_q[i] <= tag_nonce_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (accept)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_nonce[wr_ptr_q[AW-1:0]] <= tag_nonce_q[PIPE_LATENCY-1];
      fifo_hash[wr_ptr_q[AW-1:0]]  <= hash_hi;
    end
  end

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Directed bench for skein_nonce_scheduler with a fixed-latency stub core (hash_hi = nonce).
module tb_skein_nonce_scheduler;
  localparam int unsigned L  = 182;
  localparam int unsigned II = 2;
  localparam int unsigned FD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         work_valid = 1'b0, work_ready;
  logic [511:0] work_midstate = '0;
  logic [95:0]  work_data = '0;
  logic [63:0]  work_target = '0;
  logic [31:0]  work_nonce_start = '0, work_nonce_end = '0;
  logic         abort = 1'b0;
  logic [511:0] core_midstate;
  logic [95:0]  core_data;
  logic [31:0]  core_nonce;
  logic         core_issue;
  logic [511:0] core_hash;
  logic         res_valid, res_ready = 1'b0;
  logic [31:0]  res_nonce;
  logic [63:0]  res_hash_hi;
  logic         busy, done, overflow;

  skein_nonce_scheduler #(.PIPE_LATENCY(L), .ISSUE_INTERVAL(II), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .work_target(work_target),
    .work_nonce_start(work_nonce_start), .work_nonce_end(work_nonce_end), .abort(abort),
    .core_midstate(core_midstate), .core_data(core_data), .core_nonce(core_nonce),
    .core_issue(core_issue), .core_hash(core_hash), .res_valid(res_valid),
    .res_ready(res_ready), .res_nonce(res_nonce), .res_hash_hi(res_hash_hi),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Stub core: L-stage delay of the presented nonce, hash_hi = zero-extended nonce.
  logic [31:0] stub [L];
  always @(posedge clk) begin
    stub[0] <= core_nonce;
    for (int i = 1; i < L; i++) stub[i] <= stub[i-1];
  end
  assign core_hash = {32'h0, stub[L-1], 448'h0};

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [63:0] target;
    int          n_issue;
    int          n_win;
  } vec_t;

  vec_t vecs [4];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start_work(input logic [31:0] s, input logic [31:0] e,
                            input logic [63:0] tgt, input logic ab);
    int n = 0;
    while (work_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("work_ready_idle", work_ready, 1);
    work_midstate    = {16{s}};
    work_data        = {3{~s}};
    work_target      = tgt;
    work_nonce_start = s;
    work_nonce_end   = e;
    work_valid       = 1'b1;
    abort            = ab;
    @(negedge clk);
    work_valid = 1'b0;
    abort      = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("overflow_clear_on_accept", overflow, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (core_issue !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, core_issue, 1);
  endtask

  task automatic pop_check(input logic [31:0] exp);
    chk("pop_valid", res_valid, 1);
    chk("pop_nonce", res_nonce, exp);
    chk("pop_hash_hi", res_hash_hi, {32'h0, exp});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] q [$];
    logic [31:0] exp_n, n;
    int t = 0, n_iss = 0, n_pop = 0, last_t = -1, done_t = -1;
    for (int k = 0; k < v.n_issue; k++) begin
      n = v.start + k;
      if ({32'h0, n} <= v.target) q.push_back(n);
    end
    exp_n = v.start;
    res_ready = 1'b1;
    start_work(v.start, v.stop, v.target, 1'b0);
    work_midstate = '1;
    while (t < 1000 && !(done_t >= 0 && t > done_t + 1 && !res_valid)) begin
      if (core_issue) begin
        chk("issue_nonce", core_nonce, exp_n);
        if (n_iss > 0) chk("issue_spacing", t - last_t, II);
        exp_n  = exp_n + 1;
        last_t = t;
        n_iss++;
      end
      if (res_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_win: got %h want none", res_nonce);
        end else begin
          chk("win_nonce", res_nonce, q[0]);
          chk("win_hash_hi", res_hash_hi, {32'h0, q[0]});
          void'(q.pop_front());
        end
        n_pop++;
      end
      if (done && done_t < 0) begin
        done_t = t;
        chk("done_latency", t - last_t, L + 2);
        chk("ready_low_with_done", work_ready, 0);
      end else if (done_t >= 0 && t == done_t + 1) begin
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", work_ready, 1);
      end
      @(negedge clk);
      t++;
    end
    res_ready = 1'b0;
    chk("done_seen", done_t >= 0, 1);
    chk("issue_count", n_iss, v.n_issue);
    chk("win_count", n_pop, v.n_win);
    chk("missing_wins", q.size(), 0);
    chk("overflow_clean", overflow, 0);
    chk("idle_after_run", busy, 0);
    chk("midstate_held", core_midstate == {16{v.start}}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bogus = 0;
    vecs[0] = '{start: 32'h10,       stop: 32'h13, target: 64'h11, n_issue: 4, n_win: 2};
    vecs[1] = '{start: 32'hFFFFFFFE, stop: 32'h1,  target: 64'h0,  n_issue: 4, n_win: 1};
    vecs[2] = '{start: 32'h5,        stop: 32'h5,  target: '1,     n_issue: 1, n_win: 1};
    vecs[3] = '{start: 32'h100,      stop: 32'h107, target: 64'h103, n_issue: 8, n_win: 4};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_work_ready", work_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_issue", core_issue, 0);
    chk("rst_core_nonce", core_nonce, 0);
    chk("rst_core_data", core_data == '0, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a long sweep.
    start_work(32'h0, 32'hFFFF, '1, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_issue", core_issue, 0);
    chk("async_rst_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * L) begin
      @(negedge clk);
      if (res_valid) bogus++;
    end
    chk("no_stale_win", bogus, 0);

    // Fill the FIFO and drop two winners.
    start_work(32'h20, 32'h25, '1, 1'b0);
    wait_done("full_done");
    chk("full_overflow", overflow, 1);
    chk("full_head", res_nonce, 32'h20);
    pop_check(32'h20);
    pop_check(32'h21);

    // Abort three cycles after the first issue; in-flight nonces must never land.
    start_work(32'h40, 32'h4F, '1, 1'b0);
    wait_issue("abort_first_issue");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_idle", busy, 0);
    chk("abort_no_issue", core_issue, 0);
    repeat (2 * L) @(negedge clk);
    pop_check(32'h22);
    pop_check(32'h23);
    chk("no_push_after_abort", res_valid, 0);

    // Refill exactly to full, then pop in the same cycle as the next push.
    start_work(32'h30, 32'h33, '1, 1'b0);
    wait_done("refill_done");
    chk("refill_no_overflow", overflow, 0);
    chk("refill_head", res_nonce, 32'h30);
    start_work(32'h50, 32'h50, '1, 1'b1);
    wait_issue("single_issue");
    chk("single_nonce", core_nonce, 32'h50);
    repeat (L) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("push_pop_full_no_drop", overflow, 0);
    wait_done("single_done");
    pop_check(32'h31);
    pop_check(32'h32);
    pop_check(32'h33);
    pop_check(32'h50);
    chk("fifo_empty_end", res_valid, 0);
    chk("overflow_end", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
